// File: rtl/tpc_arbiter_if.sv
// tpc_arbiter_if
//   Bundles the PIO register-write port, the four requester streams and the
//   hififo tpc0 write port of tpc_arbiter. The signal names match the original
//   flat port names, so existing instances only need to hook up the bundle.
//   The master modport is the arbiter's view. The slave modport is the view of
//   the surrounding logic (PIO host, requesters and hififo).
//
//   pio_write_valid / pio_write_data / pio_address : PIO register write
//   req_data[64i+63:64i] / req_valid[i] / req_ready[i] : requester i
//   tpc_data / tpc_write / tpc_ready                : hififo tpc0 port
//   grant_id / busy                                 : arbiter status
interface tpc_arbiter_if;
  logic         pio_write_valid;
  logic [63:0]  pio_write_data;
  logic [12:0]  pio_address;
  logic [255:0] req_data;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [63:0]  tpc_data;
  logic         tpc_write;
  logic         tpc_ready;
  logic [1:0]   grant_id;
  logic         busy;

  modport master (
    input  pio_write_valid, pio_write_data, pio_address,
    input  req_data, req_valid, tpc_ready,
    output req_ready, tpc_data, tpc_write, grant_id, busy
  );

  modport slave (
    output pio_write_valid, pio_write_data, pio_address,
    output req_data, req_valid, tpc_ready,
    input  req_ready, tpc_data, tpc_write, grant_id, busy
  );
endinterface

// File: rtl/tpc_arbiter.sv
// tpc_arbiter
//   Round-robin burst arbiter that merges four 64-bit requester streams into
//   the single hififo tpc0 write port. A granted requester owns the port for up
//   to blen words (0 = 256). The burst ends early when the requester runs dry or
//   is disabled. Each new grant costs one dead cycle in IDLE.
//
//   clock : single clock (fifo_clock domain)
//   reset : synchronous, active-high
//   bus   : tpc_arbiter_if.master (PIO regs, requesters, tpc port, status)
//
//   PIO registers: PIO_BASE   -> enable mask en[3:0]   (reset 4'hF)
//                  PIO_BASE+1 -> burst length blen[7:0] (reset 16)
module tpc_arbiter #(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned PIO_BASE = 16
) (
  input  logic          clock,
  input  logic          reset,
  tpc_arbiter_if.master bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  en_q, en_d;
  logic [7:0]  blen_q, blen_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [1:0]  grant_q, grant_d;
  logic        tpc_write_q;
  logic [63:0] tpc_data_q;

  logic [8:0]  blen_eff;
  logic [3:0]  elig;
  logic        found;
  logic [1:0]  pick;
  logic [1:0]  idx;
  logic        active;
  logic        xfer;
  logic [3:0]  req_ready_c;

  // Only the low bits of the PIO data are architected.
  logic unused_pio_bits;
  assign unused_pio_bits = ^bus.pio_write_data[63:8];

  always_comb begin
    blen_eff = (blen_q == 8'd0) ? 9'd256 : {1'b0, blen_q};
    elig     = en_q & bus.req_valid;

    // Round-robin search starting one past the last grant.
    found = 1'b0;
    pick  = grant_q;
    idx   = grant_q;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = grant_q + 2'(k);
      if (!found && elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end

    // The granted requester may only be offered a slot while it is still
    // enabled and below the current burst length. A cleared enable or a shrunk
    // blen therefore stops transfers at once, and the FSM leaves on the next
    // edge.
    active = (state_q == BURST) && en_q[grant_q] && (cnt_q < blen_eff);

    req_ready_c = '0;
    if (active) begin
      req_ready_c[grant_q] = bus.tpc_ready;
    end
    xfer = active && bus.tpc_ready && bus.req_valid[grant_q];
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    blen_d  = blen_q;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        if (!active) begin
          state_d = IDLE;
        end else if (bus.tpc_ready) begin
          if (!bus.req_valid[grant_q]) begin
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 9'd1;
            if ((cnt_q + 9'd1) >= blen_eff) begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (bus.pio_write_valid) begin
      if (bus.pio_address == 13'(PIO_BASE)) begin
        en_d = bus.pio_write_data[3:0];
      end
      if (bus.pio_address == 13'(PIO_BASE + 1)) begin
        blen_d = bus.pio_write_data[7:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      en_q        <= 4'hF;
      blen_q      <= 8'd16;
      cnt_q       <= '0;
      grant_q     <= 2'd3;
      tpc_write_q <= 1'b0;
      tpc_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      blen_q      <= blen_d;
      cnt_q       <= cnt_d;
      grant_q     <= grant_d;
      tpc_write_q <= xfer;
      if (xfer) begin
        tpc_data_q <= bus.req_data[{grant_q, 6'd0} +: 64];
      end
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.tpc_write = tpc_write_q;
  assign bus.tpc_data  = tpc_data_q;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = (state_q == BURST);

endmodule

// File: tb/tb_tpc_arbiter.sv
module tb_tpc_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tpc_arbiter_if bus ();

  tpc_arbiter #(.N_REQ(4), .PIO_BASE(16)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  int unsigned src_cnt [4];
  int unsigned src_lim [4];

  int          run_len   [$];
  int          run_gap   [$];
  int          run_gid   [$];
  logic [63:0] run_first [$];
  logic [63:0] wr_data   [$];
  bit          in_run;
  int          gap;
  int          total_wr;

  function automatic logic [63:0] mk(input int unsigned i, input int unsigned c);
    return {32'(i), 32'(c)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic update_src();
    for (int i = 0; i < 4; i++) begin
      bus.req_valid[i] = (src_cnt[i] < src_lim[i]);
      bus.req_data[64*i +: 64] = mk(i, src_cnt[i]);
    end
  endtask

  task automatic clear_log();
    run_len.delete();
    run_gap.delete();
    run_gid.delete();
    run_first.delete();
    wr_data.delete();
    in_run   = 1'b0;
    gap      = 0;
    total_wr = 0;
  endtask

  // One clock: requesters see acceptance, then the tpc port is logged.
  task automatic tick();
    logic [3:0] acc;
    @(negedge clk);
    acc = bus.req_valid & bus.req_ready & {4{~rst}};
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (acc[i]) src_cnt[i]++;
    update_src();
    if (bus.tpc_write) begin
      total_wr++;
      wr_data.push_back(bus.tpc_data);
      if (!in_run) begin
        run_len.push_back(1);
        run_gap.push_back(gap);
        run_gid.push_back(int'(bus.grant_id));
        run_first.push_back(bus.tpc_data);
        in_run = 1'b1;
      end else begin
        run_len[run_len.size()-1]++;
      end
    end else begin
      if (in_run) begin
        in_run = 1'b0;
        gap    = 1;
      end else begin
        gap++;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.pio_write_valid = 1'b0;
    bus.pio_write_data  = '0;
    bus.pio_address     = '0;
    bus.tpc_ready       = 1'b1;
    for (int i = 0; i < 4; i++) begin
      src_cnt[i] = 0;
      src_lim[i] = 0;
    end
    update_src();
    tick();
    tick();
    rst = 1'b0;
    clear_log();
  endtask

  task automatic pio_wr(input logic [12:0] a, input logic [63:0] d);
    bus.pio_write_valid = 1'b1;
    bus.pio_address     = a;
    bus.pio_write_data  = d;
    tick();
    bus.pio_write_valid = 1'b0;
  endtask

  task automatic wait_writes(input int n, input string tag);
    int k = 0;
    while (total_wr < n && k < 1000) begin
      tick();
      k++;
    end
    chk(tag, 64'(total_wr >= n), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (bus.busy && k < 1000) begin
      tick();
      k++;
    end
    chk(tag, 64'(bus.busy), 64'd0);
  endtask

  task automatic stop_src();
    for (int i = 0; i < 4; i++) src_lim[i] = src_cnt[i];
    update_src();
  endtask

  initial begin
    int k;

    // Reset state
    do_reset();
    chk("rst_tpc_write", 64'(bus.tpc_write), 64'd0);
    chk("rst_tpc_data",  bus.tpc_data,       64'd0);
    chk("rst_grant_id",  64'(bus.grant_id),  64'd3);
    chk("rst_busy",      64'(bus.busy),      64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);

    // Single streamer, blen=16: bursts 16,16,8 separated by one idle cycle
    src_lim[0] = 40;
    update_src();
    wait_writes(40, "t1_wait");
    tick();
    chk("t1_busy_end", 64'(bus.busy), 64'd0);
    chk("t1_nruns",    64'(run_len.size()), 64'd3);
    chk("t1_run0", 64'(run_len[0]), 64'd16);
    chk("t1_run1", 64'(run_len[1]), 64'd16);
    chk("t1_run2", 64'(run_len[2]), 64'd8);
    chk("t1_gap1", 64'(run_gap[1]), 64'd1);
    chk("t1_gap2", 64'(run_gap[2]), 64'd1);
    for (int j = 0; j < 40; j++) chk($sformatf("t1_data%0d", j), wr_data[j], mk(0, j));

    // All four valid, blen=4: grants 0,1,2,3,0, four writes each
    do_reset();
    pio_wr(13'd17, 64'd4);
    clear_log();
    for (int i = 0; i < 4; i++) src_lim[i] = 1000;
    update_src();
    repeat (26) tick();
    stop_src();
    wait_idle("t2_idle");
    chk("t2_nruns_ge5", 64'(run_len.size() >= 5), 64'd1);
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("t2_len%0d", j), 64'(run_len[j]), 64'd4);
      chk($sformatf("t2_gid%0d", j), 64'(run_gid[j]), 64'(j % 4));
      if (j > 0) chk($sformatf("t2_gap%0d", j), 64'(run_gap[j]), 64'd1);
    end
    chk("t2_first4", run_first[4], mk(0, 4));

    // tpc_ready stall mid-burst: no writes, counter frozen, total stays blen
    do_reset();
    src_lim[1] = 100;
    update_src();
    wait_writes(5, "t3_wait5");
    bus.tpc_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      chk($sformatf("t3_stall_wr%0d", j), 64'(bus.tpc_write), 64'd0);
      chk($sformatf("t3_stall_busy%0d", j), 64'(bus.busy), 64'd1);
    end
    chk("t3_src_frozen", 64'(src_cnt[1]), 64'd5);
    bus.tpc_ready = 1'b1;
    k = 0;
    while (bus.busy && k < 100) begin
      tick();
      k++;
    end
    stop_src();
    chk("t3_idle", 64'(bus.busy), 64'd0);
    chk("t3_total", 64'(total_wr), 64'd16);
    chk("t3_last", wr_data[15], mk(1, 15));
    tick();

    // Disable req0 mid-burst: last transfer on the PIO edge, then req1
    do_reset();
    src_lim[0] = 100;
    src_lim[1] = 100;
    update_src();
    wait_writes(3, "t4_wait3");
    pio_wr(13'd16, 64'hE);
    chk("t4_k_write", 64'(bus.tpc_write), 64'd1);
    chk("t4_k_busy",  64'(bus.busy),      64'd1);
    tick();
    chk("t4_k1_write", 64'(bus.tpc_write), 64'd0);
    chk("t4_k1_busy",  64'(bus.busy),      64'd0);
    chk("t4_req0_cnt", 64'(src_cnt[0]),    64'd4);
    tick();
    chk("t4_regrant_busy", 64'(bus.busy),     64'd1);
    chk("t4_regrant_gid",  64'(bus.grant_id), 64'd1);
    tick();
    chk("t4_req1_write", 64'(bus.tpc_write), 64'd1);
    chk("t4_req1_data",  bus.tpc_data,       mk(1, 0));
    stop_src();
    wait_idle("t4_idle");

    // blen=0: 256 words from req2, one idle cycle, re-grant to req2
    do_reset();
    pio_wr(13'd17, 64'd0);
    clear_log();
    src_lim[2] = 300;
    update_src();
    k = 0;
    while (run_len.size() < 2 && k < 700) begin
      tick();
      k++;
    end
    chk("t5_two_runs", 64'(run_len.size() >= 2), 64'd1);
    chk("t5_len0",     64'(run_len[0]), 64'd256);
    chk("t5_gid0",     64'(run_gid[0]), 64'd2);
    chk("t5_last0",    wr_data[255],    mk(2, 255));
    chk("t5_gap1",     64'(run_gap[1]), 64'd1);
    chk("t5_gid1",     64'(run_gid[1]), 64'd2);
    chk("t5_first1",   run_first[1],    mk(2, 256));
    stop_src();
    wait_idle("t5_idle");

    // Reset pulse after 3 words; a coincident PIO write is ignored
    do_reset();
    pio_wr(13'd16, 64'h8);
    clear_log();
    src_lim[3] = 100;
    update_src();
    wait_writes(3, "t6_wait3");
    chk("t6_gid_before", 64'(bus.grant_id), 64'd3);
    rst = 1'b1;
    bus.pio_write_valid = 1'b1;
    bus.pio_address     = 13'd16;
    bus.pio_write_data  = 64'h0;
    tick();
    chk("t6_rst_write", 64'(bus.tpc_write), 64'd0);
    chk("t6_rst_busy",  64'(bus.busy),      64'd0);
    chk("t6_rst_ready", 64'(bus.req_ready), 64'd0);
    chk("t6_req3_cnt",  64'(src_cnt[3]),    64'd3);
    rst = 1'b0;
    bus.pio_write_valid = 1'b0;
    src_lim[3] = src_cnt[3];
    src_lim[2] = src_cnt[2] + 10;
    update_src();
    tick();
    chk("t6_en_busy", 64'(bus.busy),     64'd1);
    chk("t6_en_gid",  64'(bus.grant_id), 64'd2);
    stop_src();
    wait_idle("t6_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tpc_arbiter.md
TPC_ARBITER -- requirements
Module: tpc_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requester streams (fixed at 4 for this revision).
REQ-002 SHALL have parameter PIO_BASE, default 16, PIO address of the enable-mask register; PIO_BASE+1 is the burst-length register.
REQ-003 SHALL have port clock  input  1  single clock for all logic (fifo_clock domain of hififo).
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port pio_write_valid  input  1  PIO write strobe.
REQ-006 SHALL have port pio_write_data  input  64  PIO write data.
REQ-007 SHALL have port pio_address  input  13  PIO write address.
REQ-008 SHALL have port req_data  input  256  requester words, requester i on bits [64i+63:64i].
REQ-009 SHALL have port req_valid  input  4  requester i has a word.
REQ-010 SHALL have port req_ready  output  4  requester i word accepted this cycle when valid and ready are both high.
REQ-011 SHALL have port tpc_data  output  64  word to hififo tpc0_data.
REQ-012 SHALL have port tpc_write  output  1  to hififo tpc0_write.
REQ-013 SHALL have port tpc_ready  input  1  from hififo tpc0_ready.
REQ-014 SHALL have port grant_id  output  2  currently or last granted requester.
REQ-015 SHALL have port busy  output  1  high while in BURST state.

Function
REQ-016 SHALL keep enable mask en[3:0]; a PIO write to PIO_BASE loads pio_write_data[3:0].
REQ-017 SHALL keep burst length blen[7:0]; a PIO write to PIO_BASE+1 loads pio_write_data[7:0]; blen 0 means 256 words.
REQ-018 SHALL treat a requester as eligible only when en[i] and req_valid[i] are both high.
REQ-019 SHALL implement a 2-state FSM: IDLE and BURST.
REQ-020 In IDLE, if any requester is eligible, the FSM SHALL grant the first eligible requester in round-robin order starting at (last grant + 1) mod 4, load grant_id, clear the 9-bit word counter and enter BURST next cycle.
REQ-021 In IDLE, req_ready SHALL be 0.
REQ-022 In BURST, req_ready[grant_id] SHALL equal tpc_ready (combinational); all other bits SHALL be 0.
REQ-023 Transfer: req_valid[g] and req_ready[g] high; on that edge tpc_data <= req_data[g], tpc_write <= 1 and the counter increments.
REQ-024 tpc_write SHALL be 0 on every edge without a transfer; latency requester to tpc is exactly 1 cycle.
REQ-025 BURST SHALL return to IDLE on the edge where the transfer count reaches blen (256 when blen is 0).
REQ-026 BURST SHALL also return to IDLE on any edge where req_valid[g] is low, so a stalled requester releases the FIFO.
REQ-027 While tpc_ready is low, BURST SHALL hold state and counter, with no transfer and no exit.
REQ-028 Clearing en[g] mid-burst SHALL end the burst; the PIO write lands on edge k, the last possible transfer is on edge k, and IDLE is entered on edge k+1.
REQ-029 A blen write mid-burst SHALL take effect at the next comparison; if count is already at or above the new blen, the burst ends on the next edge.
REQ-030 IDLE to BURST SHALL cost one dead cycle; back-to-back bursts from different requesters are therefore separated by 1 cycle.
REQ-031 The round-robin pointer SHALL advance only on grant; with a single eligible requester it is re-granted after each burst.
REQ-032 busy SHALL be high exactly in BURST.

Reset
REQ-033 Reset SHALL force, on the next edge: state IDLE, en=4'hF, blen=8'd16, counter 0, grant_id=3 (so requester 0 is first), tpc_write=0, tpc_data=0.
REQ-034 Reset asserted mid-burst SHALL abort without further transfers; req_ready SHALL be 0 in the cycle after the reset edge.
REQ-035 A PIO write coincident with reset SHALL be ignored.

Verification
REQ-036 Req0 streams 0..39, others idle, blen=16, tpc_ready=1 -> bursts of 16, 16, 8 words, each separated by one idle cycle; tpc_data is 0..39 in order.
REQ-037 All 4 valid continuously, blen=4 -> grant order 0,1,2,3,0; each burst is exactly 4 writes; no interleaving within a burst.
REQ-038 tpc_ready low for 5 cycles mid-burst -> no writes, counter frozen, burst resumes and totals blen.
REQ-039 Write en=4'b1110 during a req0 burst -> req0 stops within 1 edge; next grant goes to req1.
REQ-040 blen=0 with req2 alone valid -> 256 consecutive writes, then 1 idle cycle, then re-grant to req2.
REQ-041 Reset pulse after 3 words of a burst -> tpc_write=0 and busy=0 next cycle; en reads back as 4'hF (next burst honours all requesters).
